lsu_data_port: RTL

//  Load/store unit between the execute stage and the word-wide data memory (mem).

---
 rtl/lsu_data_port_pkg.sv | 56 +++++
 rtl/lsu_data_port_if.sv | 42 ++++
 rtl/lsu_data_port_align.sv | 53 +++++
 rtl/lsu_data_port.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/lsu_data_port_pkg.sv
// ============================================================================
// Module   : lsu_data_port_pkg
// Purpose  : Shared types, funct3 encodings and request-check helper for the
//            load/store unit data port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_data_port_pkg;

  localparam int XLEN          = 32;
  localparam int DATA_MEM_SIZE = 256;
  localparam int WORD_ADDR_LSB = 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE      = 2'b00,
    LSU_LOAD_WAIT = 2'b01,
    LSU_RMW_WRITE = 2'b10
  } lsu_state_e;

  typedef enum logic [1:0] {
    LSU_ERR_NONE     = 2'b00,
    LSU_ERR_MISALIGN = 2'b01,
    LSU_ERR_FAULT    = 2'b10,
    LSU_ERR_ILLEGAL  = 2'b11
  } lsu_err_e;

  // Classify a request; ILLEGAL wins over MISALIGN, which wins over FAULT.
  function automatic lsu_err_e lsu_check(input logic            we,
                                         input logic [2:0]      funct3,
                                         input logic [XLEN-1:0] addr,
                                         input logic [XLEN-1:0] mem_words);
    logic            illegal;
    logic            misalign;
    logic [XLEN-1:0] word_idx;
    illegal  = we ? (funct3 > F3_W)
                  : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
    // funct3[1:0] gives the access size for every legal encoding
    misalign = (funct3[1:0] == 2'b01 && addr[0]) ||
               (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    word_idx = {2'b00, addr[XLEN-1:WORD_ADDR_LSB]};
    if (illegal)                    return LSU_ERR_ILLEGAL;
    else if (misalign)              return LSU_ERR_MISALIGN;
    else if (word_idx >= mem_words) return LSU_ERR_FAULT;
    else                            return LSU_ERR_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_data_port_if.sv
// ============================================================================
// Module   : lsu_data_port_if
// Purpose  : Request/response handshake and word-memory bus of the LSU.
//            slave  = the LSU side, master = execute stage + memory side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_data_port_if;
  import lsu_data_port_pkg::*;

  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [2:0]      req_funct3_i;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic            rsp_valid_o;
  logic [XLEN-1:0] rsp_rdata_o;
  logic [1:0]      rsp_err_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [XLEN-1:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    input  mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    output mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

`default_nettype wire

// File: rtl/lsu_data_port_align.sv
// ============================================================================
// Module   : lsu_data_align
// Purpose  : Combinational lane logic: little-endian load extraction with
//            sign/zero extension, and sub-word store merge into an old word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_data_align
  import lsu_data_port_pkg::*;
(
  input  wire logic [XLEN-1:0] i_rdata,
  input  wire logic [XLEN-1:0] i_wdata,
  input  wire logic [1:0]      i_offset,
  input  wire logic [2:0]      i_funct3,
  output logic      [XLEN-1:0] o_load_data,
  output logic      [XLEN-1:0] o_store_data
);

  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_mask;

  assign w_shamt   = {i_offset, 3'b000};
  assign w_shifted = i_rdata >> w_shamt;

  // Bring the addressed lane down to bit 0, then extend to a full word.
  always_comb begin
    o_load_data = i_rdata;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
      F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_load_data = {24'h0, w_shifted[7:0]};
      F3_HU:   o_load_data = {16'h0, w_shifted[15:0]};
      default: o_load_data = i_rdata;
    endcase
  end

  // Replace only the target lane(s) of the old word with the store data.
  always_comb begin
    w_mask = '1;
    case (i_funct3)
      F3_B:    w_mask = 32'h0000_00FF;
      F3_H:    w_mask = 32'h0000_FFFF;
      default: w_mask = '1;
    endcase
    o_store_data = (i_rdata & ~(w_mask << w_shamt)) |
                   ((i_wdata & w_mask) << w_shamt);
  end

endmodule

`default_nettype wire

// File: rtl/lsu_data_port.sv
// ============================================================================
// Module   : lsu_data_port
// Purpose  : Load/store unit between execute and a word-wide data memory.
//            Byte addresses become word indices; SB/SH use read-modify-write;
//            one registered response per request.
//            Optional macro LSU_PERF_CNT_EN adds load/store/error counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_data_port
  import lsu_data_port_pkg::*;
#(
  parameter int MEM_WORDS = DATA_MEM_SIZE
) (
  input  wire logic         clk_i,
  input  wire logic         rst_n_i,
  lsu_data_port_if.slave    bus
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_loads_o,
  output logic [31:0]       perf_stores_o,
  output logic [31:0]       perf_errs_o
`endif
);

  lsu_state_e      r_state;
  logic [XLEN-1:0] r_addr;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_wdata;
  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_rdata;
  lsu_err_e        r_rsp_err;

  logic            w_accept;
  lsu_err_e        w_err;
  logic            w_sw_ok;
  logic [XLEN-1:0] w_req_idx;
  logic [XLEN-1:0] w_lat_idx;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_store_data;

  assign w_accept  = bus.req_valid_i && (r_state == LSU_IDLE);
  assign w_err     = lsu_check(bus.req_we_i, bus.req_funct3_i, bus.req_addr_i,
                               XLEN'(MEM_WORDS));
  assign w_sw_ok   = w_accept && bus.req_we_i && (bus.req_funct3_i == F3_W) &&
                     (w_err == LSU_ERR_NONE);
  assign w_req_idx = {2'b00, bus.req_addr_i[XLEN-1:WORD_ADDR_LSB]};
  assign w_lat_idx = {2'b00, r_addr[XLEN-1:WORD_ADDR_LSB]};

  assign bus.req_ready_o = (r_state == LSU_IDLE);
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_err_o   = r_rsp_err;

  lsu_data_align u_align (
    .i_rdata      (bus.mem_rdata_i),
    .i_wdata      (r_wdata),
    .i_offset     (r_addr[1:0]),
    .i_funct3     (r_funct3),
    .o_load_data  (w_load_data),
    .o_store_data (w_store_data)
  );

  // Memory bus: IDLE passes the request address through (read for loads and
  // RMW, write for SW); later states address the latched word.
  always_comb begin
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = w_req_idx;
    bus.mem_wdata_o = bus.req_wdata_i;
    case (r_state)
      LSU_IDLE: begin
        bus.mem_we_o = rst_n_i && w_sw_ok;
      end
      LSU_LOAD_WAIT: begin
        bus.mem_addr_o  = w_lat_idx;
        bus.mem_wdata_o = '0;
      end
      LSU_RMW_WRITE: begin
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = w_lat_idx;
        bus.mem_wdata_o = w_store_data;
      end
      default: begin
        bus.mem_we_o = 1'b0;
      end
    endcase
  end

  // Control FSM with registered one-cycle response pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= LSU_IDLE;
      r_addr      <= '0;
      r_funct3    <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= LSU_ERR_NONE;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        LSU_IDLE: begin
          if (w_accept) begin
            if (w_err != LSU_ERR_NONE) begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_err   <= w_err;
            end else if (bus.req_we_i && bus.req_funct3_i == F3_W) begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_err   <= LSU_ERR_NONE;
            end else begin
              r_addr   <= bus.req_addr_i;
              r_funct3 <= bus.req_funct3_i;
              if (bus.req_we_i) begin
                r_wdata <= bus.req_wdata_i;
                r_state <= LSU_RMW_WRITE;
              end else begin
                r_state <= LSU_LOAD_WAIT;
              end
            end
          end
        end
        LSU_LOAD_WAIT: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_load_data;
          r_rsp_err   <= LSU_ERR_NONE;
          r_state     <= LSU_IDLE;
        end
        LSU_RMW_WRITE: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= '0;
          r_rsp_err   <= LSU_ERR_NONE;
          r_state     <= LSU_IDLE;
        end
        default: begin
          r_state <= LSU_IDLE;
        end
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic [31:0] r_perf_loads;
  logic [31:0] r_perf_stores;
  logic [31:0] r_perf_errs;

  // Count responses as they are registered; error responses only hit errs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_perf_loads  <= '0;
      r_perf_stores <= '0;
      r_perf_errs   <= '0;
    end else begin
      if (r_state == LSU_LOAD_WAIT)
        r_perf_loads <= r_perf_loads + 32'd1;
      if (r_state == LSU_RMW_WRITE || w_sw_ok)
        r_perf_stores <= r_perf_stores + 32'd1;
      if (w_accept && w_err != LSU_ERR_NONE)
        r_perf_errs <= r_perf_errs + 32'd1;
    end
  end

  assign perf_loads_o  = r_perf_loads;
  assign perf_stores_o = r_perf_stores;
  assign perf_errs_o   = r_perf_errs;
`endif

endmodule

`default_nettype wire
